// File: rtl/mips_exec_mem_if.sv
// ---------------------------------------------------------------------------
// mips_exec_mem_if
//
// Bundles the execute/memory slice's operand inputs and its decoded control,
// ALU, and writeback outputs. Clock and reset are kept as plain ports on the
// unit itself.
//
// Modports:
//   slave  - the execute/memory unit: takes the instruction fields and
//            operands, and drives the controls and results.
//   master - the surrounding datapath or testbench: drives the instruction
//            fields and operands, and observes the controls and results.
//
// Signals:
//   opcode, funct       instruction fields instr[31:26] and instr[5:0]
//   src_a, rd2          register file read ports (rd2 is also the store data)
//   sign_imm            sign-extended immediate
//   mem_to_reg ... jump main-decoder controls, plus pc_src = branch & zero
//   alu_control         decoded ALU operation
//   alu_result, zero    ALU output and its zero flag
//   mem_rdata, result   data-memory read data and writeback value
// ---------------------------------------------------------------------------
interface mips_exec_mem_if #(
    parameter int DATA_W = 32
);
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] sign_imm;

    logic              mem_to_reg;
    logic              mem_write;
    logic              pc_src;
    logic              alu_src;
    logic              reg_dst;
    logic              reg_write;
    logic              jump;
    logic [2:0]        alu_control;
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] result;

    modport slave (
        input  opcode, funct, src_a, rd2, sign_imm,
        output mem_to_reg, mem_write, pc_src, alu_src, reg_dst, reg_write,
               jump, alu_control, alu_result, zero, mem_rdata, result
    );

    modport master (
        output opcode, funct, src_a, rd2, sign_imm,
        input  mem_to_reg, mem_write, pc_src, alu_src, reg_dst, reg_write,
               jump, alu_control, alu_result, zero, mem_rdata, result
    );
endinterface

// File: rtl/mips_exec_mem_unit.sv
// ---------------------------------------------------------------------------
// mips_exec_mem_unit
//
// Single-cycle MIPS execute/memory slice. It contains the following parts:
//   - the main decoder and the ALU decoder
//   - a DATA_W-bit ALU
//   - a 2^ADDR_W-word data memory
//   - the memory-to-register writeback mux
//
// Everything is combinational except the data memory. A store lands on the
// rising clock edge. Reads are asynchronous, so a read returns the new word
// as soon as the edge has passed.
//
// Ports:
//   clk    rising-edge clock, used only by data-memory writes
//   rst_n  asynchronous active-low reset; clears every memory word and holds
//          the memory at zero while low
//   bus    mips_exec_mem_if.slave; carries the operands in and the
//          controls and results out
//
// Parameters:
//   ADDR_W  memory word-index width (depth = 2^ADDR_W words)
//   DATA_W  data and ALU width
// ---------------------------------------------------------------------------
module mips_exec_mem_unit #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mips_exec_mem_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    // Opcodes recognised by the main decoder
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // aluop classes passed from the main decoder to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Signed comparison used by slt. It is kept as a function so that both
    // operands are handled as two's-complement values.
    function automatic logic signed_less(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a < b);
    endfunction

    logic              reg_write_c;
    logic              reg_dst_c;
    logic              alu_src_c;
    logic              branch_c;
    logic              mem_write_c;
    logic              mem_to_reg_c;
    logic              jump_c;
    logic [1:0]        aluop_c;
    logic [2:0]        alu_ctl_c;

    logic signed [DATA_W-1:0] op_a;
    logic signed [DATA_W-1:0] op_b;
    logic [DATA_W-1:0]        alu_y;
    logic                     alu_zero;

    logic [ADDR_W-1:0] word_idx;
    logic [DATA_W-1:0] mem_words [DEPTH];
    logic [DATA_W-1:0] rdata;

    // ---------------------------------------------------------------------
    // Main decoder. Unknown opcodes fall through to all-zero controls, so a
    // bad instruction can neither write the register file nor write memory.
    // ---------------------------------------------------------------------
    always_comb begin
        reg_write_c  = 1'b0;
        reg_dst_c    = 1'b0;
        alu_src_c    = 1'b0;
        branch_c     = 1'b0;
        mem_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        jump_c       = 1'b0;
        aluop_c      = ALUOP_ADD;
        case (bus.opcode)
            OP_RTYPE: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                aluop_c     = ALUOP_FUNCT;
            end
            OP_LW: begin
                reg_write_c  = 1'b1;
                alu_src_c    = 1'b1;
                mem_to_reg_c = 1'b1;
            end
            OP_SW: begin
                alu_src_c   = 1'b1;
                mem_write_c = 1'b1;
            end
            OP_BEQ: begin
                branch_c = 1'b1;
                aluop_c  = ALUOP_SUB;
            end
            OP_ADDI: begin
                reg_write_c = 1'b1;
                alu_src_c   = 1'b1;
            end
            OP_J: begin
                jump_c = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // ALU decoder. aluop 11 never comes out of the main decoder; it is
    // treated as add so that the case statement is complete.
    // ---------------------------------------------------------------------
    always_comb begin
        alu_ctl_c = ALU_ADD;
        case (aluop_c)
            ALUOP_SUB: alu_ctl_c = ALU_SUB;
            ALUOP_FUNCT: begin
                case (bus.funct)
                    FN_ADD:  alu_ctl_c = ALU_ADD;
                    FN_SUB:  alu_ctl_c = ALU_SUB;
                    FN_AND:  alu_ctl_c = ALU_AND;
                    FN_OR:   alu_ctl_c = ALU_OR;
                    FN_SLT:  alu_ctl_c = ALU_SLT;
                    default: alu_ctl_c = ALU_ADD;
                endcase
            end
            default: alu_ctl_c = ALU_ADD;
        endcase
    end

    // ---------------------------------------------------------------------
    // ALU. Add and subtract wrap modulo 2^DATA_W, and the carry is dropped.
    // beq relies on the subtract producing zero when the operands are equal.
    // ---------------------------------------------------------------------
    assign op_a = bus.src_a;
    assign op_b = alu_src_c ? bus.sign_imm : bus.rd2;

    always_comb begin
        alu_y = '0;
        case (alu_ctl_c)
            ALU_AND: alu_y = op_a & op_b;
            ALU_OR:  alu_y = op_a | op_b;
            ALU_ADD: alu_y = op_a + op_b;
            ALU_SUB: alu_y = op_a - op_b;
            ALU_SLT: alu_y = {{(DATA_W-1){1'b0}}, signed_less(op_a, op_b)};
            default: alu_y = '0;
        endcase
    end

    assign alu_zero = (alu_y == '0);

    // ---------------------------------------------------------------------
    // Data memory. The word index drops the byte offset and ignores the
    // upper address bits, so byte addresses wrap modulo 4*DEPTH. Each word
    // is its own register with an asynchronous clear. Asserting rst_n
    // between clock edges therefore zeroes the memory at once, and a store
    // presented while rst_n is low is discarded.
    // ---------------------------------------------------------------------
    assign word_idx = alu_y[ADDR_W+1:2];

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [DATA_W-1:0] word_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (mem_write_c && (word_idx == ADDR_W'(i))) begin
                word_q <= bus.rd2;
            end
        end

        assign mem_words[i] = word_q;
    end

    assign rdata = mem_words[word_idx];

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.reg_write   = reg_write_c;
    assign bus.reg_dst     = reg_dst_c;
    assign bus.alu_src     = alu_src_c;
    assign bus.mem_write   = mem_write_c;
    assign bus.mem_to_reg  = mem_to_reg_c;
    assign bus.jump        = jump_c;
    assign bus.pc_src      = branch_c & alu_zero;
    assign bus.alu_control = alu_ctl_c;
    assign bus.alu_result  = alu_y;
    assign bus.zero        = alu_zero;
    assign bus.mem_rdata   = rdata;
    assign bus.result      = mem_to_reg_c ? rdata : alu_y;

endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_exec_mem_unit
//
// Self-checking bench for mips_exec_mem_unit. The reference model has three
// parts:
//   - a table of the main-decoder controls indexed by opcode
//   - ALU arithmetic written directly from the operation definitions
//   - a 64-entry word array for the data memory
// ---------------------------------------------------------------------------
module tb_mips_exec_mem_unit;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mips_exec_mem_if #(.DATA_W(32)) bus ();

    mips_exec_mem_unit #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] ref_mem [64];

    // Observed controls in the same packing as exp_t.ctrl:
    // {reg_write, reg_dst, alu_src, mem_write, mem_to_reg, jump, pc_src,
    //  alu_control[2:0], zero}
    logic [10:0] act_ctrl;
    assign act_ctrl = {bus.reg_write, bus.reg_dst, bus.alu_src, bus.mem_write,
                       bus.mem_to_reg, bus.jump, bus.pc_src, bus.alu_control,
                       bus.zero};

    typedef struct {
        logic [10:0] ctrl;
        logic [31:0] y;
        logic [31:0] res;
        int          word;
    } exp_t;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    // Main-decoder table entry: {rw, rd, as, br, mw, m2r, j, aluop[1:0]}
    function automatic logic [8:0] model_ctrl(input logic [5:0] op);
        case (op)
            OP_R:    return 9'b1100000_10;
            OP_LW:   return 9'b1010010_00;
            OP_SW:   return 9'b0010100_00;
            OP_BEQ:  return 9'b0001000_01;
            OP_ADDI: return 9'b1010000_00;
            OP_J:    return 9'b0000001_00;
            default: return 9'b0000000_00;
        endcase
    endfunction

    function automatic logic [2:0] model_alu_ctl(input logic [1:0] aluop, input logic [5:0] fn);
        if (aluop == 2'b01) return 3'b110;
        if (aluop != 2'b10) return 3'b010;
        case (fn)
            FN_SUB:  return 3'b110;
            FN_AND:  return 3'b000;
            FN_OR:   return 3'b001;
            FN_SLT:  return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [31:0] model_alu(input logic [2:0] ctl, input logic [31:0] a,
                                              input logic [31:0] b);
        case (ctl)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [31:0] a, input logic [31:0] r2,
                                   input logic [31:0] imm);
        exp_t        e;
        logic [8:0]  c;
        logic [2:0]  ctl;
        logic        z;
        c      = model_ctrl(op);
        ctl    = model_alu_ctl(c[1:0], fn);
        e.y    = model_alu(ctl, a, c[6] ? imm : r2);
        z      = (e.y == 32'd0);
        e.word = int'((e.y >> 2) & 32'd63);
        e.res  = c[3] ? ref_mem[e.word] : e.y;
        e.ctrl = {c[8], c[7], c[6], c[4], c[3], c[2], c[5] & z, ctl, z};
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] r2, input logic [31:0] imm);
        bus.opcode   = op;
        bus.funct    = fn;
        bus.src_a    = a;
        bus.rd2      = r2;
        bus.sign_imm = imm;
        #1;
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive(OP_LW, 6'd0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        drive(OP_LW, 6'd0, 32'd0, 32'd0, 32'd8);
        vectors++;
        if (bus.result !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_lw_result: got %h want 00000000", bus.result);
        end
        rst_n = 1'b1;
        clear_ref();
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            drive(OP_LW, 6'd0, 32'd0, 32'd0, 32'(k * 4));
            vectors++;
            if (bus.mem_rdata !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_word%0d: got %h want 00000000", k, bus.mem_rdata);
            end
            vectors++;
            if (bus.mem_to_reg !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_mem_to_reg%0d: got %b want 1", k, bus.mem_to_reg);
            end
        end
    endtask

    task automatic test_sw_lw();
        @(negedge clk);
        drive(OP_SW, 6'd0, 32'h10, 32'hDEADBEEF, 32'd4);
        vectors++;
        if (bus.alu_result !== 32'h14) begin
            miscompares++;
            $display("FAIL sw_addr: got %h want 00000014", bus.alu_result);
        end
        vectors++;
        if (bus.mem_write !== 1'b1) begin
            miscompares++;
            $display("FAIL sw_mem_write: got %b want 1", bus.mem_write);
        end
        @(posedge clk);
        ref_mem[5] = 32'hDEADBEEF;
        #1;
        drive(OP_LW, 6'd0, 32'h10, 32'd0, 32'd4);
        vectors++;
        if (bus.result !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL lw_after_sw: got %h want deadbeef", bus.result);
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fns  [6] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLT};
        logic [31:0] as   [6] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'hFFFFFFFF};
        logic [31:0] bs   [6] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd1};
        logic [31:0] want [6] = '{32'd12, 32'd2, 32'd5, 32'd7, 32'd0, 32'd1};
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive(OP_R, fns[k], as[k], bs[k], 32'h1234);
            vectors++;
            if (bus.result !== want[k]) begin
                miscompares++;
                $display("FAIL rtype_fixed%0d: got %h want %h", k, bus.result, want[k]);
            end
            vectors++;
            if ({bus.reg_dst, bus.reg_write} !== 2'b11) begin
                miscompares++;
                $display("FAIL rtype_dst_write%0d: got %b%b want 11", k, bus.reg_dst, bus.reg_write);
            end
        end
        for (int k = 0; k < 40; k++) begin
            logic [5:0]  fn;
            logic [31:0] a, b;
            int sel;
            sel = $urandom_range(0, 5);
            fn  = (sel == 5) ? 6'($urandom) : fns[sel];
            a   = $urandom;
            b   = (k % 8 == 0) ? a : $urandom;
            @(negedge clk);
            drive(OP_R, fn, a, b, $urandom);
            e = model(OP_R, fn, a, b, bus.sign_imm);
            vectors++;
            if (act_ctrl !== e.ctrl || bus.result !== e.res) begin
                miscompares++;
                $display("FAIL rtype_rand fn=%b: got ctrl %b res %h want ctrl %b res %h",
                         fn, act_ctrl, bus.result, e.ctrl, e.res);
            end
        end
    endtask

    task automatic test_beq();
        @(negedge clk);
        drive(OP_BEQ, 6'd0, 32'd9, 32'd9, 32'd0);
        vectors++;
        if ({bus.zero, bus.pc_src, bus.reg_write, bus.mem_write} !== 4'b1100) begin
            miscompares++;
            $display("FAIL beq_equal: got z/pc/rw/mw %b%b%b%b want 1100",
                     bus.zero, bus.pc_src, bus.reg_write, bus.mem_write);
        end
        @(negedge clk);
        drive(OP_BEQ, 6'd0, 32'd9, 32'd8, 32'd1);
        vectors++;
        if ({bus.pc_src, bus.reg_write, bus.mem_write} !== 3'b000) begin
            miscompares++;
            $display("FAIL beq_unequal: got pc/rw/mw %b%b%b want 000",
                     bus.pc_src, bus.reg_write, bus.mem_write);
        end
    endtask

    task automatic test_addi_j();
        exp_t e;
        @(negedge clk);
        drive(OP_ADDI, 6'd0, 32'hFFFFFFFF, 32'd77, 32'd1);
        vectors++;
        if ({bus.alu_result, bus.zero, bus.alu_src, bus.reg_dst} !== {32'd0, 3'b110}) begin
            miscompares++;
            $display("FAIL addi_wrap: got y %h z %b as %b rd %b want y 0 z 1 as 1 rd 0",
                     bus.alu_result, bus.zero, bus.alu_src, bus.reg_dst);
        end
        @(negedge clk);
        drive(OP_J, 6'd0, 32'd3, 32'd4, 32'd5);
        vectors++;
        if ({bus.jump, bus.reg_write, bus.mem_write} !== 3'b100) begin
            miscompares++;
            $display("FAIL j_ctrl: got j/rw/mw %b%b%b want 100", bus.jump, bus.reg_write, bus.mem_write);
        end
        @(negedge clk);
        drive(6'b111111, 6'd0, 32'd0, 32'd0, 32'd0);
        vectors++;
        if (act_ctrl[10:4] !== 7'd0) begin
            miscompares++;
            $display("FAIL op_3f_ctrl: got %b want 0000000", act_ctrl[10:4]);
        end
        for (int k = 0; k < 20; k++) begin
            logic [5:0] op;
            op = 6'($urandom);
            if (op == OP_SW) op = 6'b111110;
            @(negedge clk);
            drive(op, 6'($urandom), $urandom, $urandom, $urandom);
            e = model(op, bus.funct, bus.src_a, bus.rd2, bus.sign_imm);
            vectors++;
            if (act_ctrl !== e.ctrl || bus.result !== e.res) begin
                miscompares++;
                $display("FAIL opcode_rand op=%b: got ctrl %b res %h want ctrl %b res %h",
                         op, act_ctrl, bus.result, e.ctrl, e.res);
            end
        end
    endtask

    task automatic test_random_mem();
        exp_t e;
        for (int k = 0; k < 60; k++) begin
            logic        is_sw;
            logic [31:0] a, imm, d;
            is_sw = (k < 20) ? 1'b1 : 1'($urandom);
            a     = $urandom;
            imm   = $urandom;
            d     = $urandom;
            @(negedge clk);
            drive(is_sw ? OP_SW : OP_LW, 6'd0, a, d, imm);
            e = model(bus.opcode, 6'd0, a, d, imm);
            vectors++;
            if (act_ctrl !== e.ctrl || bus.result !== e.res) begin
                miscompares++;
                $display("FAIL mem_rand%0d: got ctrl %b res %h want ctrl %b res %h",
                         k, act_ctrl, bus.result, e.ctrl, e.res);
            end
            if (is_sw) begin
                @(posedge clk);
                ref_mem[e.word] = d;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] data [8];
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            data[k] = $urandom;
            drive(OP_SW, 6'd0, 32'h40, data[k], 32'(k * 4));
            @(posedge clk);
            ref_mem[16 + k] = data[k];
            #1;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(OP_LW, 6'd0, 32'h40, 32'd0, 32'(k * 4));
            vectors++;
            if (bus.result !== data[k]) begin
                miscompares++;
                $display("FAIL b2b_word%0d: got %h want %h", k, bus.result, data[k]);
            end
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        drive(OP_SW, 6'd0, 32'h100, 32'hA5A5_0F0F, 32'd0);
        @(posedge clk);
        ref_mem[0] = 32'hA5A5_0F0F;
        #1;
        drive(OP_LW, 6'd0, 32'd0, 32'd0, 32'd0);
        vectors++;
        if (bus.mem_rdata !== 32'hA5A5_0F0F) begin
            miscompares++;
            $display("FAIL wrap_0x100: got %h want a5a50f0f", bus.mem_rdata);
        end
    endtask

    task automatic test_reset_midcycle();
        @(negedge clk);
        drive(OP_SW, 6'd0, 32'h20, 32'h1357_9BDF, 32'd0);
        @(posedge clk);
        #1;
        drive(OP_LW, 6'd0, 32'h20, 32'd0, 32'd0);
        vectors++;
        if (bus.mem_rdata !== 32'h1357_9BDF) begin
            miscompares++;
            $display("FAIL midrst_before: got %h want 13579bdf", bus.mem_rdata);
        end
        #1;
        rst_n = 1'b0;
        clear_ref();
        #1;
        vectors++;
        if (bus.mem_rdata !== 32'd0 || bus.result !== 32'd0) begin
            miscompares++;
            $display("FAIL midrst_clear: got rdata %h result %h want 0 0", bus.mem_rdata, bus.result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_in_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(OP_SW, 6'd0, 32'd12, 32'hCAFE_F00D, 32'd0);
        @(posedge clk);
        #1;
        drive(OP_LW, 6'd0, 32'd12, 32'd0, 32'd0);
        vectors++;
        if (bus.mem_rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_store_during: got %h want 00000000", bus.mem_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(OP_LW, 6'd0, 32'd12, 32'd0, 32'd0);
        vectors++;
        if (bus.result !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_store_after: got %h want 00000000", bus.result);
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_rtype();
        test_beq();
        test_addi_j();
        test_random_mem();
        test_back_to_back();
        test_wrap();
        test_reset_midcycle();
        test_store_in_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
